stream_sink_checker: RTL and testbench
======================================

STREAM_SINK_CHECKER -- requirements
Module: stream_sink_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the checked data bus.
REQ-002 Parameter CNT_WIDTH, default 16: width of the item and error counters.
REQ-003 Parameter LFSR_SEED, default 8'hA5: nonzero seed of the backpressure LFSR.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 start  in  1  one-cycle pulse; arms a new check run.
REQ-007 num_items  in  CNT_WIDTH  items to accept in the run; sampled on start.
REQ-008 first_value  in  DATA_WIDTH  expected value of the first item; sampled on start.
REQ-009 stall_mode  in  2  ready pattern: 0 always, 1 alternate, 2 LFSR, 3 one-in-four; sampled on start.
REQ-010 data_out  in  DATA_WIDTH  stream data from the upstream FIFO.
REQ-011 data_out_vld  in  1  stream valid from the upstream FIFO.
REQ-012 data_out_rdy  out  1  stream ready to the upstream FIFO.
REQ-013 busy  out  1  high while state is RUN.
REQ-014 done  out  1  high while state is DONE.
REQ-015 rcv_count  out  CNT_WIDTH  items accepted in the current or last run.
REQ-016 err_count  out  CNT_WIDTH  mismatching items, saturating at all-ones.
REQ-017 first_err_idx  out  CNT_WIDTH  index (0-based) of the first mismatching item.
REQ-018 first_err_data  out  DATA_WIDTH  received data of the first mismatching item.

Function
REQ-019 A transfer SHALL occur on a rising edge where data_out_vld and data_out_rdy are both 1; no other edge changes rcv_count, err_count or the expected value.
REQ-020 data_out_rdy SHALL be a registered output, never combinationally dependent on data_out_vld or data_out.
REQ-021 FSM states: IDLE, RUN, DONE; IDLE --start, num_items!=0--> RUN; IDLE --start, num_items==0--> DONE; RUN --transfer with rcv_count==num_items-1--> DONE; DONE --start--> RUN or DONE per num_items as from IDLE.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 On start the block SHALL clear rcv_count, err_count, first_err_idx, first_err_data, load expected=first_value, reload LFSR with LFSR_SEED and clear the pattern phase counter.
REQ-024 On each transfer: mismatch if data_out!=expected; expected increments modulo 2^DATA_WIDTH (8'hFF -> 8'h00); rcv_count increments.
REQ-025 On the first mismatch of a run, first_err_idx SHALL capture the pre-increment rcv_count and first_err_data SHALL capture data_out; later mismatches do not overwrite.
REQ-026 err_count SHALL saturate at 2^CNT_WIDTH-1.
REQ-027 data_out_rdy SHALL be 0 in IDLE and DONE, including the cycle after the final transfer.
REQ-028 In RUN, data_out_rdy for cycle k (k=0 first RUN cycle): mode 0 -> 1; mode 1 -> 1 when k even; mode 2 -> LFSR bit 0; mode 3 -> 1 when k mod 4 == 0.
REQ-029 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances once per RUN cycle regardless of transfers.
REQ-030 data_out_vld dropping without a transfer SHALL cause no state change; the block never requires vld to stay high.
REQ-031 Results (counts, first error) SHALL hold stable in DONE until the next start.

Reset
REQ-032 On rst=0, asynchronously: state IDLE, data_out_rdy=0, busy=0, done=0, all counters and captures 0, expected 0, LFSR=LFSR_SEED.
REQ-033 Reset asserted mid-RUN SHALL abort the run with no done indication; the first edge after rst=1 sees IDLE.

Verification
REQ-034 Mode 0, first_value=8'h10, num_items=5, source sends 10..14 back-to-back -> rdy high 5 cycles then 0, done=1, rcv_count=5, err_count=0.
REQ-035 first_value=8'hFE, num_items=4, data FE,FF,00,01 -> err_count=0 (wrap-around accepted).
REQ-036 first_value=0, num_items=6, data 0,1,7,3,9,5 -> err_count=2, first_err_idx=2, first_err_data=8'h07.
REQ-037 Mode 1 and mode 3 with vld held high, num_items=4 -> transfers only on k even / k mod 4==0; run ends after 7 / 13 RUN cycles; rdy=0 after last transfer.
REQ-038 start with num_items=0 -> DONE next cycle, rdy never asserted; start while busy -> ignored, counters unchanged.
REQ-039 rst pulsed low after 3 of 8 transfers -> all outputs 0 immediately; new start then completes 8 items with rcv_count=8.

Source files
------------

// File: rtl/stream_sink_checker.sv
// Stream sink that accepts a counting sequence under a programmable ready pattern
// and tallies mismatches against the expected incrementing value.
module stream_sink_checker #(
   parameter int          DATA_WIDTH = 8,
   parameter int          CNT_WIDTH  = 16,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_items,
   input  logic [DATA_WIDTH-1:0] first_value,
   input  logic [1:0]            stall_mode,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  data_out_vld,
   output logic                  data_out_rdy,
   output logic                  busy,
   output logic                  done,
   output logic [CNT_WIDTH-1:0]  rcv_count,
   output logic [CNT_WIDTH-1:0]  err_count,
   output logic [CNT_WIDTH-1:0]  first_err_idx,
   output logic [DATA_WIDTH-1:0] first_err_data
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  target;
   logic [DATA_WIDTH-1:0] expected;
   logic [1:0]            mode;
   logic [1:0]            phase;
   logic [7:0]            lfsr, lfsr_nxt;
   logic                  rdy;
   logic                  xfer, last, start_ok, mismatch;

   // Ready for RUN cycle k; ph is k mod 4, lbit is the LFSR bit 0 in cycle k.
   function automatic logic pattern(input logic [1:0] m, input logic [1:0] ph, input logic lbit);
      case (m)
         2'd0:    pattern = 1'b1;
         2'd1:    pattern = ~ph[0];
         2'd2:    pattern = lbit;
         default: pattern = (ph == 2'd0);
      endcase
   endfunction

   assign data_out_rdy = rdy;
   assign xfer     = (state == RUN) && rdy && data_out_vld;
   assign last     = (rcv_count == target - CNT_WIDTH'(1));
   assign start_ok = start && (state != RUN);
   assign mismatch = (data_out != expected);
   assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (xfer && last) state_nxt = DONE;
         default: if (start) state_nxt = (num_items != '0) ? RUN : DONE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         target         <= '0;
         expected       <= '0;
         mode           <= 2'd0;
         phase          <= 2'd0;
         lfsr           <= LFSR_SEED;
         rdy            <= 1'b0;
         rcv_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else if (start_ok) begin
         target         <= num_items;
         expected       <= first_value;
         mode           <= stall_mode;
         phase          <= 2'd0;
         lfsr           <= LFSR_SEED;
         rdy            <= (num_items != '0) && pattern(stall_mode, 2'd0, LFSR_SEED[0]);
         rcv_count      <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else if (state == RUN) begin
         // Pattern state advances every RUN cycle; rdy drops right after the final transfer.
         lfsr  <= lfsr_nxt;
         phase <= phase + 2'd1;
         rdy   <= (xfer && last) ? 1'b0 : pattern(mode, phase + 2'd1, lfsr_nxt[0]);
         if (xfer) begin
            expected  <= expected + DATA_WIDTH'(1);
            rcv_count <= rcv_count + CNT_WIDTH'(1);
            if (mismatch) begin
               if (err_count != '1) err_count <= err_count + CNT_WIDTH'(1);
               if (err_count == '0) begin
                  first_err_idx  <= rcv_count;
                  first_err_data <= data_out;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_sink_checker.sv
// Directed bench for stream_sink_checker: ready patterns, error capture, wrap, reset abort.
module tb_stream_sink_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_items;
   logic [7:0]  first_value;
   logic [1:0]  stall_mode;
   logic [7:0]  data_out;
   logic        data_out_vld;
   logic        data_out_rdy;
   logic        busy;
   logic        done;
   logic [15:0] rcv_count;
   logic [15:0] err_count;
   logic [15:0] first_err_idx;
   logic [7:0]  first_err_data;

   int          vec  = 0;
   int          miss = 0;
   logic [7:0]  src [16];
   int          cyc;
   logic [31:0] trace;

   stream_sink_checker dut (
      .clk(clk), .rst(rst), .start(start), .num_items(num_items),
      .first_value(first_value), .stall_mode(stall_mode),
      .data_out(data_out), .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy),
      .busy(busy), .done(done), .rcv_count(rcv_count), .err_count(err_count),
      .first_err_idx(first_err_idx), .first_err_data(first_err_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [15:0] n, input logic [7:0] fv, input logic [1:0] m);
      start = 1'b1; num_items = n; first_value = fv; stall_mode = m;
      tick();
      start = 1'b0;
   endtask

   // Source with vld held high presenting src[] in order; records rdy per RUN cycle.
   task automatic feed(input int maxcyc, output int ncyc, output logic [31:0] tr);
      int  idx = 0;
      logic x;
      ncyc = 0; tr = '0;
      while (busy && ncyc < maxcyc) begin
         data_out_vld = 1'b1;
         data_out     = src[idx & 15];
         x            = data_out_rdy;
         tr[ncyc]     = data_out_rdy;
         tick();
         if (x) idx++;
         ncyc++;
      end
      data_out_vld = 1'b0;
      chk("run_ended", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; num_items = '0; first_value = '0;
      stall_mode = '0; data_out = '0; data_out_vld = 1'b0;
      tick(); tick();
      chk("rst_rdy",  {31'd0, data_out_rdy}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_rcv",  {16'd0, rcv_count}, 32'd0);
      chk("rst_err",  {16'd0, err_count}, 32'd0);
      chk("rst_fidx", {16'd0, first_err_idx}, 32'd0);
      chk("rst_fdat", {24'd0, first_err_data}, 32'd0);
      rst = 1'b1;
      tick();

      // mode 0, 10..14 back to back
      for (int i = 0; i < 5; i++) src[i] = 8'h10 + 8'(i);
      do_start(16'd5, 8'h10, 2'd0);
      feed(20, cyc, trace);
      chk("m0_cycles", cyc, 32'd5);
      chk("m0_trace",  trace, 32'b11111);
      chk("m0_rdy_after", {31'd0, data_out_rdy}, 32'd0);
      chk("m0_done", {31'd0, done}, 32'd1);
      chk("m0_rcv",  {16'd0, rcv_count}, 32'd5);
      chk("m0_err",  {16'd0, err_count}, 32'd0);

      // wrap-around FE,FF,00,01
      src[0] = 8'hFE; src[1] = 8'hFF; src[2] = 8'h00; src[3] = 8'h01;
      do_start(16'd4, 8'hFE, 2'd0);
      feed(20, cyc, trace);
      chk("wrap_rcv", {16'd0, rcv_count}, 32'd4);
      chk("wrap_err", {16'd0, err_count}, 32'd0);

      // two mismatches, first at index 2
      src[0] = 8'h00; src[1] = 8'h01; src[2] = 8'h07;
      src[3] = 8'h03; src[4] = 8'h09; src[5] = 8'h05;
      do_start(16'd6, 8'h00, 2'd0);
      feed(20, cyc, trace);
      chk("err_rcv",  {16'd0, rcv_count}, 32'd6);
      chk("err_cnt",  {16'd0, err_count}, 32'd2);
      chk("err_fidx", {16'd0, first_err_idx}, 32'd2);
      chk("err_fdat", {24'd0, first_err_data}, 32'h07);
      data_out = 8'h55;
      tick(); tick(); tick();
      chk("hold_err",  {16'd0, err_count}, 32'd2);
      chk("hold_fidx", {16'd0, first_err_idx}, 32'd2);
      chk("hold_done", {31'd0, done}, 32'd1);

      // mode 1: transfers on even k, 7 RUN cycles
      for (int i = 0; i < 4; i++) src[i] = 8'h20 + 8'(i);
      do_start(16'd4, 8'h20, 2'd1);
      feed(30, cyc, trace);
      chk("m1_cycles", cyc, 32'd7);
      chk("m1_trace",  trace, 32'b1010101);
      chk("m1_rdy_after", {31'd0, data_out_rdy}, 32'd0);
      chk("m1_err", {16'd0, err_count}, 32'd0);

      // mode 3: transfers on k mod 4 == 0, 13 RUN cycles
      do_start(16'd4, 8'h20, 2'd3);
      feed(30, cyc, trace);
      chk("m3_cycles", cyc, 32'd13);
      chk("m3_trace",  trace, 32'b1000100010001);
      chk("m3_rcv", {16'd0, rcv_count}, 32'd4);

      // mode 2: seed A5 gives ready bits 1,0,1,0,0,1,1
      do_start(16'd4, 8'h20, 2'd2);
      feed(30, cyc, trace);
      chk("m2_cycles", cyc, 32'd7);
      chk("m2_trace",  trace, 32'b1100101);
      chk("m2_err", {16'd0, err_count}, 32'd0);

      // num_items == 0 goes straight to DONE with counters cleared
      do_start(16'd0, 8'h00, 2'd0);
      chk("zero_done", {31'd0, done}, 32'd1);
      chk("zero_busy", {31'd0, busy}, 32'd0);
      chk("zero_rdy",  {31'd0, data_out_rdy}, 32'd0);
      chk("zero_rcv",  {16'd0, rcv_count}, 32'd0);
      tick();
      chk("zero_rdy2", {31'd0, data_out_rdy}, 32'd0);

      // start while busy is ignored
      do_start(16'd3, 8'h40, 2'd1);
      data_out_vld = 1'b1; data_out = 8'h40;
      tick();
      data_out_vld = 1'b0;
      start = 1'b1; num_items = 16'd1; first_value = 8'h00; stall_mode = 2'd0;
      tick();
      start = 1'b0;
      chk("busy_ign_busy", {31'd0, busy}, 32'd1);
      chk("busy_ign_rcv",  {16'd0, rcv_count}, 32'd1);
      src[0] = 8'h41; src[1] = 8'h42;
      feed(20, cyc, trace);
      chk("busy_ign_trace", trace, 32'b101);
      chk("busy_ign_rcv2",  {16'd0, rcv_count}, 32'd3);
      chk("busy_ign_err",   {16'd0, err_count}, 32'd0);

      // reset after 3 of 8 transfers aborts, then a fresh run completes
      do_start(16'd8, 8'h00, 2'd0);
      for (int i = 0; i < 3; i++) begin
         data_out_vld = 1'b1; data_out = 8'(i);
         tick();
      end
      data_out_vld = 1'b0;
      chk("abort_pre_rcv", {16'd0, rcv_count}, 32'd3);
      rst = 1'b0;
      #1;
      chk("abort_rdy",  {31'd0, data_out_rdy}, 32'd0);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_rcv",  {16'd0, rcv_count}, 32'd0);
      tick();
      rst = 1'b1;
      tick();
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
      chk("abort_idle_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) src[i] = 8'(i);
      do_start(16'd8, 8'h00, 2'd0);
      feed(30, cyc, trace);
      chk("rerun_rcv",  {16'd0, rcv_count}, 32'd8);
      chk("rerun_err",  {16'd0, err_count}, 32'd0);
      chk("rerun_done", {31'd0, done}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
